bitcount_mdu: RTL and testbench

- Multi-cycle bit-count functional unit for the CPU datapath, sequenced like the mult/div unit.
- Accepts a 32-bit operand and a count mode on a start pulse.
- Scans CHUNK bits per cycle, raises busy while running, pulses done, and holds the 6-bit result until the next completion.
- The pipeline stalls on busy, and can cancel in-flight work on a flush.

---
 rtl/bitcount_mdu.sv | 127 ++++++++++++
 tb/tb_bitcount_mdu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bitcount_mdu.sv
// Multi-cycle bit-count unit: popcount, zero count, CLZ or CTZ over a 32-bit operand,
// consuming CHUNK bits per cycle with mult/div-style start/busy/done/cancel sequencing.
module bitcount_mdu #(
  parameter int unsigned CHUNK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] numin,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [5:0]  numout
);

  localparam int unsigned N        = 32 / CHUNK;
  localparam logic [4:0]  LastStep = 5'(N - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] operand_q, operand_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  count_q, count_d;
  logic [4:0]  step_q, step_d;
  logic        found_q, found_d;
  logic        done_q, done_d;
  logic [5:0]  numout_q, numout_d;

  logic [31:0]      numin_rev;
  logic [CHUNK-1:0] chunk;
  logic [5:0]       ones, zeros, lead;
  logic             seen;

  // CLZ is stored bit-reversed so every mode scans LSB-first from the bottom chunk.
  always_comb begin
    numin_rev = {<<{numin}};
  end

  always_comb begin
    chunk = operand_q[CHUNK-1:0];
    ones  = '0;
    lead  = '0;
    seen  = 1'b0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      ones = ones + {5'd0, chunk[i]};
      if (!seen) begin
        if (chunk[i]) seen = 1'b1;
        else          lead = lead + 6'd1;
      end
    end
    zeros = 6'(CHUNK) - ones;
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    op_d      = op_q;
    count_d   = count_q;
    step_d    = step_q;
    found_d   = found_q;
    numout_d  = numout_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          state_d   = StRun;
          operand_d = (op == 2'b10) ? numin_rev : numin;
          op_d      = op;
          count_d   = '0;
          step_d    = '0;
          found_d   = 1'b0;
        end
      end
      StRun: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          operand_d = operand_q >> CHUNK;
          step_d    = step_q + 5'd1;
          unique case (op_q)
            2'b00:   count_d = count_q + ones;
            2'b01:   count_d = count_q + zeros;
            default: begin
              if (!found_q) count_d = count_q + lead;
              found_d = found_q | seen;
            end
          endcase
          if (step_q == LastStep) begin
            state_d  = StIdle;
            numout_d = count_d;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      operand_q <= '0;
      op_q      <= '0;
      count_q   <= '0;
      step_q    <= '0;
      found_q   <= 1'b0;
      done_q    <= 1'b0;
      numout_q  <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      count_q   <= count_d;
      step_q    <= step_d;
      found_q   <= found_d;
      done_q    <= done_d;
      numout_q  <= numout_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = done_q;
  assign numout = numout_q;

endmodule

// File: tb/tb_bitcount_mdu.sv
// Directed bench for bitcount_mdu: CHUNK=4 main instance plus a CHUNK=1 instance
// sharing the same stimulus for the latency-scaling check.
module tb_bitcount_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] numin = '0;
  logic        busy, done, busy1, done1;
  logic [5:0]  numout, numout1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bitcount_mdu #(.CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .numin(numin), .cancel(cancel),
    .busy(busy), .done(done), .numout(numout)
  );

  bitcount_mdu #(.CHUNK(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .numin(numin), .cancel(cancel),
    .busy(busy1), .done(done1), .numout(numout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  // Inputs are scrambled right after acceptance to confirm the operand is latched.
  task automatic run_op(input bit sel, input logic [1:0] o, input logic [31:0] v,
                        input int exp_n, input logic [5:0] exp_val, input string tag);
    int   k, nbusy;
    logic d, b;
    start = 1'b1;
    op    = o;
    numin = v;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    numin = ~v;
    k     = 0;
    nbusy = 0;
    d = sel ? done1 : done;
    b = sel ? busy1 : busy;
    while (!d && k < 40) begin
      if (b) nbusy++;
      @(negedge clk);
      k++;
      d = sel ? done1 : done;
      b = sel ? busy1 : busy;
    end
    check({tag, " latency"}, k, exp_n);
    check({tag, " busy_cycles"}, nbusy, exp_n);
    check({tag, " result"}, sel ? numout1 : numout, exp_val);
    check({tag, " busy_at_done"}, b, 1'b0);
  endtask

  initial begin
    int ndone;
    #12;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst numout", numout, 6'd0);
    check("rst numout1", numout1, 6'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(0, 2'b00, 32'hffffffff, 8, 6'd32, "ones_all");
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("numout_hold", numout, 6'd32);
    run_op(0, 2'b00, 32'hffffefff, 8, 6'd31, "ones_31");

    // Chain starting each op in the done cycle of the previous: 9 cycles done-to-done.
    run_op(0, 2'b01, 32'hffffff00, 8, 6'd8,  "b2b zeros");
    run_op(0, 2'b11, 32'hff000000, 8, 6'd24, "b2b ctz");
    run_op(0, 2'b10, 32'h00010000, 8, 6'd15, "b2b clz");
    run_op(0, 2'b10, 32'h00000000, 8, 6'd32, "clz_zero");
    run_op(0, 2'b11, 32'h00000000, 8, 6'd32, "ctz_zero");
    run_op(0, 2'b10, 32'h80000000, 8, 6'd0,  "clz_msb");
    run_op(0, 2'b11, 32'h80000000, 8, 6'd31, "ctz_msb");
    run_op(0, 2'b00, 32'h12345678, 8, 6'd13, "ones_mix");
    run_op(0, 2'b01, 32'h12345678, 8, 6'd19, "zeros_mix");
    run_op(0, 2'b00, 32'hffffffff, 8, 6'd32, "ones_again");

    // Cancel seen on the third RUN edge.
    @(negedge clk);
    start = 1'b1; op = 2'b00; numin = 32'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", busy, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("cancel no_done", ndone, 0);
    check("cancel numout", numout, 6'd32);

    // Cancel on the completion edge beats done.
    start = 1'b1; op = 2'b00; numin = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("cancel_last busy_before", busy, 1'b1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_last busy", busy, 1'b0);
    check("cancel_last done", done, 1'b0);
    check("cancel_last numout", numout, 6'd32);

    // start with cancel in IDLE is refused.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b00; numin = 32'h0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start_cancel busy", busy, 1'b0);
    @(negedge clk);
    check("start_cancel done", done, 1'b0);
    check("start_cancel numout", numout, 6'd32);

    // Asynchronous reset mid-RUN, checked between clock edges.
    start = 1'b1; op = 2'b01; numin = 32'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst busy", busy, 1'b0);
    check("async_rst numout", numout, 6'd0);
    check("async_rst done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("async_rst no_done", ndone, 0);
    check("async_rst numout_after", numout, 6'd0);

    run_op(1, 2'b00, 32'hffffffff, 32, 6'd32, "c1 ones_all");
    run_op(1, 2'b00, 32'hffffefff, 32, 6'd31, "c1 ones_31");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
